// File: rtl/relu_grad_unit.sv
// ReLU backward gate: forward side queues one sign-mask bit per activation,
// backward side pops one bit per gradient and passes or zeroes it.
// Optional: define RELU_GRAD_LEAKY_EN to pass mask-0 gradients as grad >>> LEAK_SHIFT.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module relu_grad_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    fwd_valid,
  output logic                    fwd_ready,
  input  logic [DATA_WIDTH-1:0]   fwd_act,
  input  logic                    bwd_in_valid,
  output logic                    bwd_in_ready,
  input  logic [DATA_WIDTH-1:0]   bwd_in_grad,
  output logic                    bwd_out_valid,
  input  logic                    bwd_out_ready,
  output logic [DATA_WIDTH-1:0]   bwd_out_grad,
  output logic [$clog2(DEPTH):0]  mask_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0]      mask_mem;
  logic [AW-1:0]         wptr, rptr;
  logic                  push, pop, mask_in, mask_out;
  logic [DATA_WIDTH-1:0] gated;

  assign mask_in  = $signed(fwd_act) > 0;
  assign mask_out = mask_mem[rptr];

  // Ready depends on registered state only, so a same-cycle pop never frees a full FIFO.
  assign fwd_ready    = (mask_count != (AW+1)'(DEPTH));
  assign bwd_in_ready = (mask_count != '0) && (!bwd_out_valid || bwd_out_ready);

  assign push = fwd_valid    && fwd_ready    && !clear;
  assign pop  = bwd_in_valid && bwd_in_ready && !clear;

`ifdef RELU_GRAD_LEAKY_EN
  assign gated = mask_out ? bwd_in_grad : ($signed(bwd_in_grad) >>> LEAK_SHIFT);
`else
  logic unused_leak;
  assign unused_leak = ^LEAK_SHIFT;
  assign gated = mask_out ? bwd_in_grad : '0;
`endif

  // Storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) mask_mem[wptr] <= mask_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      mask_count <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      mask_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      mask_count <= mask_count + 1'b1;
      else if (pop && !push) mask_count <= mask_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bwd_out_valid <= 1'b0;
      bwd_out_grad  <= '0;
    end else if (clear) begin
      bwd_out_valid <= 1'b0;
      bwd_out_grad  <= '0;
    end else if (pop) begin
      bwd_out_valid <= 1'b1;
      bwd_out_grad  <= gated;
    end else if (bwd_out_ready) begin
      bwd_out_valid <= 1'b0;
    end
  end

endmodule
